multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Execute-stage controller for the shared multi-cycle multiply/divide unit.
- Detects R-type mul/div in the X stage, latches operands and destination, and issues a one-cycle start pulse to the multdiv unit.
- Stalls the pipeline until the result arrives, then emits a single writeback beat. Exceptions redirect the write to $rstatus ($30).

Parameters:
- TIMEOUT, 40, max cycles spent in BUSY before forced abort; must be ≥2.
- CNT_W, 6, counter width; 2^CNT_W > TIMEOUT.
- MUL_EXC_CODE, 4, rstatus value on multiply overflow.
- DIV_EXC_CODE, 5, rstatus value on divide exception.
- TMO_EXC_CODE, 6, rstatus value on timeout.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- dx_insn  in  32  instruction in the X stage.
- dx_valid  in  1  dx_insn is a live instruction.
- dx_opA  in  32  bypassed rs value.
- dx_opB  in  32  bypassed rt value.
- flush  in  1  pipeline kill (taken branch/jump).
- md_ready  in  1  multdiv result ready (data_resultRDY).
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv exception flag.
- md_ctrl_mult  out  1  one-cycle multiply start.
- md_ctrl_div  out  1  one-cycle divide start.
- md_opA  out  32  latched operand A.
- md_opB  out  32  latched operand B.
- stall  out  1  freeze F/D/X.
- wb_valid  out  1  one-cycle write strobe.
- wb_rd  out  5  write destination.
- wb_data  out  32  write data.
- busy_cycles  out  CNT_W  cycles spent in the current BUSY.

Behaviour:
- Decode:
  - is_md = dx_valid & insn[31:27]==5'b00000 & insn[6:2] ∈ {5'b00110 (mul), 5'b00111 (div)}.
  - rd = insn[26:22].
- States: IDLE, START, BUSY, DONE.
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, latches 0.
- IDLE:
  - is_md & !flush → latch opA, opB, rd, op; go to START.
  - stall is combinationally 1 in this detection cycle.
  - Otherwise stay in IDLE with stall=0.
- START (exactly 1 cycle):
  - md_ctrl_mult or md_ctrl_div = 1 per latched op; the other stays 0.
  - counter cleared to 0; next state BUSY.
  - md_ready in this cycle is ignored as stale.
- BUSY:
  - counter increments each cycle; busy_cycles = counter.
  - md_ready=1 → capture result/exception, go to DONE.
  - counter reaching TIMEOUT-1 without md_ready → go to DONE with timeout flag set.
- DONE (exactly 1 cycle):
  - wb_valid=1. Next state IDLE.
  - Normal completion: wb_rd=latched rd, wb_data=md_result.
  - Exception: wb_rd=30, wb_data=MUL_EXC_CODE or DIV_EXC_CODE per op.
  - Timeout: wb_rd=30, wb_data=TMO_EXC_CODE.
  - Latched rd==0 with no exception/timeout → wb_valid=0.
  - wb_rd/wb_data are 0 whenever wb_valid=0.
- stall = 1 in IDLE-detect, START and BUSY; 0 in DONE, so the instruction retires on the writeback cycle.
- Latency: detect at cycle T → start pulse at T+1. First md_ready sampled in BUSY at cycle R → wb_valid at R+1.
- Operand latches are held constant from START until IDLE is re-entered.
- flush=1 in START, BUSY or DONE → next state IDLE, wb_valid forced 0 that cycle, no writeback. A later start pulse restarts the multdiv.
- flush has priority over md_ready and over timeout.
- Simultaneous flush and is_md in IDLE → instruction ignored, stall=0.
- Reset mid-operation → immediate IDLE, pending writeback discarded.

Optional Feature:
- Macro: MDSEQ_DIV0_BYPASS_EN.
- Defined: div with latched opB==0 skips the multdiv.
  - START issues no md_ctrl_div pulse and goes directly to DONE.
  - DONE writes wb_rd=30, wb_data=DIV_EXC_CODE. Total stall is 2 cycles.
- Undefined: div by zero goes through the multdiv like any other div, and relies on md_exception.

Test Plan:
- mul, rd=3, A=6, B=7; md_ready at the 10th BUSY cycle with result 42 → md_ctrl_mult pulses once; stall high 12 cycles; wb_valid=1, wb_rd=3, wb_data=42.
- div, rd=5, A=100, B=7; md_exception=0; ready after 33 cycles → one md_ctrl_div pulse; wb_rd=5, wb_data=14; busy_cycles counts 0..32.
- mul with md_exception=1 at ready → wb_rd=30, wb_data=4. div with md_exception=1 → wb_rd=30, wb_data=5.
- md_ready never asserted, TIMEOUT=40 → exits BUSY after 40 cycles; wb_rd=30, wb_data=6; stall drops in DONE.
- flush in the 5th BUSY cycle, then md_ready 2 cycles later → no wb_valid; state IDLE; stall=0. A new mul afterwards pulses md_ctrl_mult again.
- MDSEQ_DIV0_BYPASS_EN defined, div B=0 → no md_ctrl_div; wb_rd=30, wb_data=5 two cycles after detect. Undefined → pulse issued. Also: reset=0 mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the execute stage, the multdiv sequencer and
// the shared multi-cycle multiply/divide unit.
//   master : the sequencer (drives start pulses, stall and writeback)
//   slave  : the surrounding pipeline / multdiv unit
interface multdiv_sequencer_if #(
  parameter int CNT_W = 6
);

  // X-stage instruction and bypassed operands
  logic [31:0]      dx_insn;
  logic             dx_valid;
  logic [31:0]      dx_opA;
  logic [31:0]      dx_opB;
  logic             flush;

  // multdiv unit result side
  logic             md_ready;
  logic [31:0]      md_result;
  logic             md_exception;

  // multdiv unit command side
  logic             md_ctrl_mult;
  logic             md_ctrl_div;
  logic [31:0]      md_opA;
  logic [31:0]      md_opB;

  // pipeline control and writeback
  logic             stall;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] busy_cycles;

  modport master (
    input  dx_insn, dx_valid, dx_opA, dx_opB, flush,
    input  md_ready, md_result, md_exception,
    output md_ctrl_mult, md_ctrl_div, md_opA, md_opB,
    output stall, wb_valid, wb_rd, wb_data, busy_cycles
  );

  modport slave (
    output dx_insn, dx_valid, dx_opA, dx_opB, flush,
    output md_ready, md_result, md_exception,
    input  md_ctrl_mult, md_ctrl_div, md_opA, md_opB,
    input  stall, wb_valid, wb_rd, wb_data, busy_cycles
  );

endinterface

// File: rtl/multdiv_sequencer.sv
// Execute-stage controller for the shared multi-cycle multiply/divide unit.
// Detects R-type mul/div in X, latches operands and destination, fires a
// one-cycle start pulse, stalls F/D/X until the result (or a timeout)
// arrives and then emits a single writeback beat. Exceptions and timeouts
// redirect the write to $rstatus ($30).
//
// Optional build macro MDSEQ_DIV0_BYPASS_EN: a divide whose latched
// divisor is zero never reaches the multdiv; it goes START -> DONE and
// writes DIV_EXC_CODE to $rstatus after a two-cycle stall.
module multdiv_sequencer #(
  parameter int TIMEOUT      = 40,  // max BUSY cycles before forced abort (>= 2)
  parameter int CNT_W        = 6,   // 2**CNT_W must exceed TIMEOUT
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5,
  parameter int TMO_EXC_CODE = 6
) (
  input logic                clock,
  input logic                reset,   // asynchronous, active-low
  multdiv_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [4:0]       RSTATUS  = 5'd30;
  localparam logic [4:0]       FUNC_MUL = 5'b00110;
  localparam logic [4:0]       FUNC_DIV = 5'b00111;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      res_q, res_d;
  logic [4:0]       rd_q, rd_d;
  logic             div_q, div_d;   // latched op: 1 = divide, 0 = multiply
  logic             exc_q, exc_d;   // multdiv (or bypassed div-by-0) exception
  logic             tmo_q, tmo_d;   // BUSY ran out of cycles
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_md;
  logic             div0_bypass;
  logic             unused_insn_bits;

  // Decode: R-type opcode with a mul or div function field.
  assign is_md = bus.dx_valid && (bus.dx_insn[31:27] == 5'b00000) &&
                 ((bus.dx_insn[6:2] == FUNC_MUL) || (bus.dx_insn[6:2] == FUNC_DIV));

  assign unused_insn_bits = ^{bus.dx_insn[21:7], bus.dx_insn[1:0]};

`ifdef MDSEQ_DIV0_BYPASS_EN
  assign div0_bypass = div_q && (opb_q == 32'd0);
`else
  assign div0_bypass = 1'b0;
`endif

  // State register and operation latches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: transitions, operand capture, BUSY counter.
  always_comb begin
    // NOTE: hold-by-default on every branch keeps this block free of latches.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rd_d    = rd_q;
    div_d   = div_q;
    exc_d   = exc_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (is_md && !bus.flush) begin
          opa_d   = bus.dx_opA;
          opb_d   = bus.dx_opB;
          rd_d    = bus.dx_insn[26:22];
          div_d   = bus.dx_insn[2];   // only LSB of the function field differs
          state_d = S_START;
        end
      end

      S_START: begin
        // md_ready here belongs to an earlier operation and is ignored.
        cnt_d = '0;
        res_d = '0;
        exc_d = 1'b0;
        tmo_d = 1'b0;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (div0_bypass) begin
          exc_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.md_ready) begin
          res_d   = bus.md_result;
          exc_d   = bus.md_exception;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: stall, start pulses, writeback beat, busy counter view.
  always_comb begin
    bus.stall        = 1'b0;
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    bus.busy_cycles  = '0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so every output is 0 while reset is held.
        bus.stall = reset && is_md && !bus.flush;
      end

      S_START: begin
        bus.stall = 1'b1;
        if (!div0_bypass) begin
          bus.md_ctrl_mult = !div_q;
          bus.md_ctrl_div  = div_q;
        end
      end

      S_BUSY: begin
        bus.stall       = 1'b1;
        bus.busy_cycles = cnt_q;
      end

      S_DONE: begin
        // stall stays 0 so the instruction retires on the writeback cycle.
        if (!bus.flush) begin
          if (tmo_q) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = RSTATUS;
            bus.wb_data  = 32'(TMO_EXC_CODE);
          end else if (exc_q) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = RSTATUS;
            bus.wb_data  = div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          end else if (rd_q != 5'd0) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = rd_q;
            bus.wb_data  = res_q;
          end
        end
      end

      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

  assign bus.md_opA = opa_q;
  assign bus.md_opB = opb_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: each operation pushes its expected
// writeback into a scoreboard queue; a negedge monitor pops and compares
// every wb_valid beat and flags any beat nobody expected.
module tb_multdiv_sequencer;

  localparam int CNT_W = 6;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clock;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;
  wb_t  sb_q[$];

  multdiv_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multdiv_sequencer #(
    .TIMEOUT      (40),
    .CNT_W        (CNT_W),
    .MUL_EXC_CODE (4),
    .DIV_EXC_CODE (5),
    .TMO_EXC_CODE (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
    return {5'b00000, rd, 15'd0, (is_div ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  task automatic sb_push(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: compare each writeback beat, require 0 otherwise.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (bus.wb_valid === 1'b1) begin
        check("wb_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          wb_t e;
          e = sb_q.pop_front();
          check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
          check("wb_data", 64'(bus.wb_data), 64'(e.data));
        end
      end else begin
        check("wb_idle_zero", {27'd0, bus.wb_rd, bus.wb_data}, 64'd0);
      end
    end
  end

  // One operation from detect to exit (DONE, or IDLE after a flush).
  // Cycle n: 0 = detect, 1 = START, n >= 2 = BUSY cycle (n-1).
  // A stale md_ready is always driven in START to prove it is ignored.
  task automatic run_op(input string name, input bit is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input int ready_at, input logic [31:0] result, input bit exc,
                        input int flush_at, input bit exp_wb,
                        input int exp_stall, input int exp_mult, input int exp_div);
    int n      = 0;
    int stalls = 0;
    int mult_p = 0;
    int div_p  = 0;
    bit done   = 1'b0;
    next_cycle();
    bus.dx_insn      = mk_insn(is_div, rd);
    bus.dx_valid     = 1'b1;
    bus.dx_opA       = a;
    bus.dx_opB       = b;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.flush        = 1'b0;
    while (!done) begin
      sample();
      if (n == 0) check({name, "/detect_stall"}, 64'(bus.stall), 64'd1);
      if (bus.stall === 1'b1) stalls++;
      if (bus.md_ctrl_mult === 1'b1) mult_p++;
      if (bus.md_ctrl_div === 1'b1) div_p++;
      if (n == 1) begin
        check({name, "/md_opA"}, 64'(bus.md_opA), 64'(a));
        check({name, "/md_opB"}, 64'(bus.md_opB), 64'(b));
      end
      if (n >= 2 && bus.stall === 1'b1)
        check({name, "/busy_cycles"}, 64'(bus.busy_cycles), 64'(n - 2));
      if (n > 0 && bus.stall === 1'b0) begin
        done = 1'b1;
      end else if (n >= 100) begin
        check({name, "/exit_bound"}, 64'(n), 64'd0);
        done = 1'b1;
      end else begin
        next_cycle();
        n++;
        bus.dx_valid     = 1'b0;
        bus.md_ready     = (n == 1) || (ready_at > 0 && n - 1 == ready_at);
        bus.md_result    = (n == 1) ? 32'hDEAD_BEEF : result;
        bus.md_exception = (n > 1) && exc;
        bus.flush        = (flush_at > 0 && n - 1 == flush_at);
      end
    end
    check({name, "/wb_valid_at_exit"}, 64'(bus.wb_valid), 64'(exp_wb));
    check({name, "/stall_cycles"}, 64'(stalls), 64'(exp_stall));
    check({name, "/mult_pulses"}, 64'(mult_p), 64'(exp_mult));
    check({name, "/div_pulses"}, 64'(div_p), 64'(exp_div));
    next_cycle();
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.flush        = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    bus.dx_insn      = '0;
    bus.dx_valid     = 1'b0;
    bus.dx_opA       = '0;
    bus.dx_opB       = '0;
    bus.flush        = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;

    // Reset state
    #2;
    check("rst/stall", 64'(bus.stall), 64'd0);
    check("rst/ctrl", {62'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 64'd0);
    check("rst/wb", {26'd0, bus.wb_valid, bus.wb_rd, bus.wb_data}, 64'd0);
    check("rst/ops", {bus.md_opA, bus.md_opB}, 64'd0);
    check("rst/busy_cycles", 64'(bus.busy_cycles), 64'd0);
    #20;
    reset = 1'b1;

    // Non-md instruction (nonzero opcode) and invalid md slot: no stall
    next_cycle();
    bus.dx_insn  = {5'b00101, 5'd3, 15'd0, 5'b00110, 2'b00};
    bus.dx_valid = 1'b1;
    sample();
    check("nonrtype/stall", 64'(bus.stall), 64'd0);
    next_cycle();
    bus.dx_insn  = mk_insn(1'b0, 5'd3);
    bus.dx_valid = 1'b0;
    sample();
    check("invalid/stall", 64'(bus.stall), 64'd0);
    check("invalid/no_pulse", {62'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 64'd0);

    // flush together with an md instruction in IDLE: ignored
    next_cycle();
    bus.dx_valid = 1'b1;
    bus.flush    = 1'b1;
    sample();
    check("idle_flush/stall", 64'(bus.stall), 64'd0);
    next_cycle();
    bus.dx_valid = 1'b0;
    bus.flush    = 1'b0;
    sample();
    check("idle_flush/no_start", {62'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 64'd0);

    // mul rd=3, 6*7, ready at 10th BUSY cycle
    sb_push(5'd3, 32'd42);
    run_op("mul_basic", 1'b0, 5'd3, 32'd6, 32'd7, 10, 32'd42, 1'b0, 0, 1'b1, 12, 1, 0);

    // div rd=5, 100/7, ready after 33 BUSY cycles
    sb_push(5'd5, 32'd14);
    run_op("div_basic", 1'b1, 5'd5, 32'd100, 32'd7, 33, 32'd14, 1'b0, 0, 1'b1, 35, 0, 1);

    // Exceptions redirect to $rstatus
    sb_push(5'd30, 32'd4);
    run_op("mul_exc", 1'b0, 5'd6, 32'h7FFF_FFFF, 32'd2, 4, 32'd0, 1'b1, 0, 1'b1, 6, 1, 0);
    sb_push(5'd30, 32'd5);
    run_op("div_exc", 1'b1, 5'd6, 32'd9, 32'd3, 2, 32'd0, 1'b1, 0, 1'b1, 4, 0, 1);

    // md_ready never comes: 40 BUSY cycles then timeout writeback
    sb_push(5'd30, 32'd6);
    run_op("timeout", 1'b0, 5'd11, 32'd1, 32'd1, 0, 32'd0, 1'b0, 0, 1'b1, 42, 1, 0);

    // rd=0 normal completion: no writeback beat
    run_op("rd_zero", 1'b0, 5'd0, 32'd2, 32'd2, 3, 32'd4, 1'b0, 0, 1'b0, 5, 1, 0);

    // flush in 5th BUSY cycle, md_ready arrives two cycles later
    run_op("flush_busy", 1'b0, 5'd7, 32'd8, 32'd9, 0, 32'd72, 1'b0, 5, 1'b0, 7, 1, 0);
    bus.md_ready  = 1'b1;
    bus.md_result = 32'd72;
    sample();
    check("flush_busy/late_ready_wb", 64'(bus.wb_valid), 64'd0);
    check("flush_busy/late_ready_stall", 64'(bus.stall), 64'd0);
    check("flush_busy/late_ready_pulse", 64'(bus.md_ctrl_mult), 64'd0);
    next_cycle();
    bus.md_ready = 1'b0;

    // A new mul restarts the multdiv
    sb_push(5'd8, 32'd15);
    run_op("mul_after_flush", 1'b0, 5'd8, 32'd3, 32'd5, 2, 32'd15, 1'b0, 0, 1'b1, 4, 1, 0);

    // div by zero
    sb_push(5'd30, 32'd5);
`ifdef MDSEQ_DIV0_BYPASS_EN
    run_op("div0_bypass", 1'b1, 5'd9, 32'd50, 32'd0, 0, 32'd0, 1'b0, 0, 1'b1, 2, 0, 0);
`else
    run_op("div0_unit", 1'b1, 5'd9, 32'd50, 32'd0, 3, 32'd0, 1'b1, 0, 1'b1, 5, 0, 1);
`endif

    // Reset asserted mid-BUSY: all outputs drop immediately, no writeback
    next_cycle();
    bus.dx_insn  = mk_insn(1'b0, 5'd4);
    bus.dx_valid = 1'b1;
    bus.dx_opA   = 32'h1234;
    bus.dx_opB   = 32'h5678;
    sample();
    next_cycle();
    bus.dx_valid = 1'b0;
    sample();
    check("rst_mid/start_pulse", 64'(bus.md_ctrl_mult), 64'd1);
    repeat (3) next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid/stall", 64'(bus.stall), 64'd0);
    check("rst_mid/ctrl", {62'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 64'd0);
    check("rst_mid/wb", {26'd0, bus.wb_valid, bus.wb_rd, bus.wb_data}, 64'd0);
    check("rst_mid/ops", {bus.md_opA, bus.md_opB}, 64'd0);
    check("rst_mid/busy_cycles", 64'(bus.busy_cycles), 64'd0);
    #3;
    reset = 1'b1;
    next_cycle();
    bus.md_ready  = 1'b1;
    bus.md_result = 32'd99;
    sample();
    check("rst_mid/no_wb", 64'(bus.wb_valid), 64'd0);
    check("rst_mid/idle_stall", 64'(bus.stall), 64'd0);
    next_cycle();
    bus.md_ready = 1'b0;

    // Normal operation after the mid-flight reset
    sb_push(5'd12, 32'd77);
    run_op("mul_after_reset", 1'b0, 5'd12, 32'd7, 32'd11, 1, 32'd77, 1'b0, 0, 1'b1, 3, 1, 0);

    repeat (2) next_cycle();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
